// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake, a two-entry
// (main + skid) buffer, synchronous flush and a saturating stall counter.
// All state updates on the falling edge of clk; reset is asynchronous, active-high.
//
// Ports:
//   clk, reset          stage clock (negedge) and async active-high reset
//   flush               squash both entries at the next falling edge
//   in_valid/in_ready   upstream handshake; in_ready = !skid_valid
//   in_ctrl, in_data    upstream control / data bundles
//   out_valid/out_ready downstream handshake on the main entry
//   out_ctrl, out_data  main-entry bundles; out_ctrl is zero whenever out_valid=0
//   occupancy           number of held entries (0..2)
//   stall_cnt           saturating count of back-pressured edges
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic accept;
  logic drain;

  // in_ready depends only on registered state, so no input reaches it combinationally.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid_q & out_ready;

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    stall_cnt_d  = stall_cnt_q;

    if (flush) begin
      // Data is kept; only valid and control are squashed, and the input is dropped.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else begin
      if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end

      if (!main_valid_q || drain) begin
        if (skid_valid_q) begin
          // Older skid entry leaves first; in_ready is low so nothing is accepted.
          main_valid_d = 1'b1;
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = in_ctrl;
          main_data_d  = in_data;
        end else begin
          // Bubble: control zeroed so downstream write enables cannot fire.
          main_valid_d = 1'b0;
          main_ctrl_d  = '0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  bubble_ctrl_zero: assert property (@(negedge clk) disable iff (reset)
    !out_valid |-> (out_ctrl == '0));

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned CtrlW = 10;
  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [CtrlW-1:0] in_ctrl;
  logic [DataW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CtrlW-1:0] out_ctrl;
  logic [DataW-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CntW-1:0]  stall_cnt;

  int total;
  int bad;

  pipe_stage_reg #(
    .CTRL_W(CtrlW),
    .DATA_W(DataW),
    .CNT_W (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next falling edge and settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [CtrlW-1:0] c, input logic [DataW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_oc"}, {22'd0, out_ctrl}, 32'd0);
    check({tag, "_od"}, {16'd0, out_data}, 32'd0);
    check({tag, "_ir"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_occ"}, {30'd0, occupancy}, 32'd0);
    check({tag, "_sc"}, {28'd0, stall_cnt}, 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    present(1'b0, '0, '0);
    #2;
    check_reset_state("rst");
    #10;
    reset = 1'b0;

    // Stream 1..8 with out_ready held high.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      present(1'b1, 10'h3FF, DataW'(k));
      tick();
      check("stream_ov", {31'd0, out_valid}, 32'd1);
      check("stream_od", {16'd0, out_data}, k);
      check("stream_oc", {22'd0, out_ctrl}, 32'h3FF);
      check("stream_ir", {31'd0, in_ready}, 32'd1);
    end
    check("stream_sc", {28'd0, stall_cnt}, 32'd0);

    // Bubbles after streaming.
    present(1'b0, 10'h3FF, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bub_ov", {31'd0, out_valid}, 32'd0);
      check("bub_oc", {22'd0, out_ctrl}, 32'd0);
      check("bub_od", {16'd0, out_data}, 32'd8);
    end

    // Skid fill: A into main, B into skid, C held upstream.
    out_ready = 1'b0;
    present(1'b1, 10'h011, 16'h000A);
    tick();
    check("skid_a", {16'd0, out_data}, 32'hA);
    check("skid_sc0", {28'd0, stall_cnt}, 32'd0);
    present(1'b1, 10'h022, 16'h000B);
    tick();
    check("skid_occ", {30'd0, occupancy}, 32'd2);
    check("skid_ir", {31'd0, in_ready}, 32'd0);
    check("skid_hold", {16'd0, out_data}, 32'hA);
    present(1'b1, 10'h033, 16'h000C);
    tick();
    check("skid_occ2", {30'd0, occupancy}, 32'd2);
    check("skid_oc", {22'd0, out_ctrl}, 32'h011);
    check("skid_sc", {28'd0, stall_cnt}, 32'd2);
    out_ready = 1'b1;
    tick();
    check("order_b", {16'd0, out_data}, 32'hB);
    check("order_bc", {22'd0, out_ctrl}, 32'h022);
    tick();
    check("order_c", {16'd0, out_data}, 32'hC);
    check("order_cc", {22'd0, out_ctrl}, 32'h033);
    present(1'b0, '0, '0);
    tick();
    check("order_end", {31'd0, out_valid}, 32'd0);
    check("order_sc", {28'd0, stall_cnt}, 32'd2);

    // Flush with both entries full and D presented.
    out_ready = 1'b0;
    present(1'b1, 10'h044, 16'h000E);
    tick();
    present(1'b1, 10'h055, 16'h000F);
    tick();
    check("fl_pre_occ", {30'd0, occupancy}, 32'd2);
    present(1'b1, 10'h066, 16'h000D);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_ov", {31'd0, out_valid}, 32'd0);
    check("fl_oc", {22'd0, out_ctrl}, 32'd0);
    check("fl_od", {16'd0, out_data}, 32'hE);
    check("fl_occ", {30'd0, occupancy}, 32'd0);
    check("fl_ir", {31'd0, in_ready}, 32'd1);
    check("fl_sc", {28'd0, stall_cnt}, 32'd3);
    present(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    check("fl_no_d", {31'd0, out_valid}, 32'd0);
    check("fl_od2", {16'd0, out_data}, 32'hE);

    // Async reset between edges with occupancy=2.
    out_ready = 1'b0;
    present(1'b1, 10'h077, 16'h0007);
    tick();
    present(1'b1, 10'h088, 16'h0008);
    tick();
    check("ar_pre_occ", {30'd0, occupancy}, 32'd2);
    present(1'b0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("ar");
    #1;
    reset = 1'b0;

    // Saturation of the 4-bit stall counter; first capture right after reset release.
    present(1'b1, 10'h099, 16'h0009);
    tick();
    check("sat_cap", {16'd0, out_data}, 32'h9);
    check("sat_sc0", {28'd0, stall_cnt}, 32'd0);
    present(1'b0, '0, '0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sat_sc", {28'd0, stall_cnt}, (i < 15) ? i : 15);
    end
    check("sat_ov", {31'd0, out_valid}, 32'd1);
    check("sat_od", {16'd0, out_data}, 32'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. It is the general successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Any stage boundary of the pipelined processor instantiates it with its own control and data widths. Control bits are forced to zero whenever the stage holds no valid instruction, so downstream write enables can never fire on a bubble.

## Interface

Parameters:
- CTRL_W, default 10: width of the control bundle (reg_write, mem_read, alu_op, ...); zeroed on bubbles.
- DATA_W, default 128: width of the data bundle (PC, operands, immediate, register addresses); held on bubbles.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk, input, 1: stage clock; all state updates on the falling edge.
- reset, input, 1: asynchronous, active-high.
- flush, input, 1: squash both entries at the next falling edge.
- in_valid, input, 1: upstream presents an instruction.
- in_ready, output, 1: stage can accept; equals !skid_valid.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: main entry holds a valid instruction.
- out_ready, input, 1: downstream consumes the main entry this cycle.
- out_ctrl, output, CTRL_W: main-entry control; all zero when out_valid=0.
- out_data, output, DATA_W: main-entry data; retains last value when out_valid=0.
- occupancy, output, 2: main_valid + skid_valid (0..2).
- stall_cnt, output, CNT_W: saturating count of back-pressured cycles.

## Operation

- State: the main entry (main_valid, ctrl, data), which drives the outputs, and the skid entry (skid_valid, ctrl, data).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Priority at each falling edge is flush, then normal update.
- flush=1:
  - main_valid, skid_valid, main ctrl and skid ctrl are cleared.
  - Data registers are unchanged.
  - The input is dropped even when in_valid=1.
  - stall_cnt is unchanged.
- Normal update when the main entry is empty or drain=1:
  - If skid_valid: main loads the skid entry and skid_valid is cleared. No accept is possible in this cycle because in_ready=0.
  - Else if accept: main loads in_ctrl/in_data and main_valid is set.
  - Else: main_valid is cleared and out_ctrl is cleared (bubble); out_data is held.
- Normal update when the main entry is full and drain=0:
  - If accept: skid loads the input and skid_valid is set.
  - Otherwise there is no change.
- Ordering is strictly FIFO: skid contents always leave before any newer input.
- stall_cnt:
  - Increments by 1 on each falling edge where out_valid=1, out_ready=0 and flush=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- Invariant: out_valid=0 implies out_ctrl=0. Checked by assertion.

## Timing

- Reset (async, immediate): out_valid=0, out_ctrl=0, out_data=0, skid cleared, in_ready=1, occupancy=0, stall_cnt=0.
- Reset deasserted mid-stream: the first capture occurs at the first falling edge after deassertion.
- Latency: an input accepted at falling edge N is visible on the outputs immediately after edge N when the stage was empty or draining.
- Throughput: 1 instruction per cycle when out_ready is held at 1. Full throughput is sustained across a single-cycle stall with no bubble, because the skid absorbs it.
- in_ready is a pure function of registered state.
  - There is no combinational path from out_ready or in_valid to in_ready.
  - There is no combinational path from any input to any output.
- flush asserted together with drain: the drain completes downstream, but the stage still empties. Nothing is re-presented.
- Full stage (occupancy=2) with out_ready=0: in_ready=0, and state and outputs are frozen except stall_cnt.

## Test plan

1. Stream: reset, then in_valid=1 with ctrl=0x3FF, data=k for k=1..8, and out_ready=1 throughout. Required: out_valid rises one edge later; out_data emits 1..8 in order on consecutive edges; in_ready stays 1; stall_cnt=0.
2. Skid fill: stage holding A, out_ready=0, present B then C. Required:
   - B is captured into the skid.
   - occupancy=2, in_ready=0, and C is held upstream.
   - After out_ready=1, the order is A, B, C with no duplicates.
   - stall_cnt equals the number of stalled edges.
3. Flush: occupancy=2 and in_valid=1 with D, assert flush for one edge. Required: out_valid=0, out_ctrl=0, out_data unchanged, occupancy=0, in_ready=1, and D never appears.
4. Bubble: in_valid=0 for 3 edges after streaming. Required: out_valid=0 and out_ctrl=0 on each bubble edge, with out_data holding the last valid value.
5. Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 edges. Required: stall_cnt reaches 15 and stays at 15.
6. Async reset: assert reset between clock edges with occupancy=2. Required: all outputs reach their reset values without waiting for a clock edge, and in_ready=1.
